wr_port_arbiter: RTL and testbench

WR_PORT_ARBITER -- requirements
Module: wr_port_arbiter

---
 rtl/wr_port_arbiter.sv | 106 ++++++++++
 tb/tb_wr_port_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wr_port_arbiter.sv
// Four-requester round-robin write arbiter for a shared 8-entry register bank.
// A grant is held in ISSUE until the bank accepts it; entry 0 is never written.
module wr_port_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [11:0]         req_addr,
  input  logic [4*DATA_W-1:0] req_data,
  input  logic                stall,
  output logic [3:0]          ack,
  output logic                wr_valid,
  output logic [7:0]          we_onehot,
  output logic [DATA_W-1:0]   wr_data,
  output logic [7:0]          wr_count
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e              state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          win_q, win_d;
  logic [2:0]          addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                first_q, first_d;
  logic [7:0]          count_q, count_d;
  logic [2:0]          pick;

  // Returns {found, index}; scanning k downward leaves the lowest offset from ptr.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    pick     = rr_pick(req, rr_ptr_q);
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    addr_d   = addr_q;
    data_d   = data_q;
    first_d  = 1'b0;
    count_d  = count_q;
    unique case (state_q)
      StIdle: begin
        if (pick[2]) begin
          win_d   = pick[1:0];
          addr_d  = req_addr[3*int'(pick[1:0]) +: 3];
          data_d  = req_data[DATA_W*int'(pick[1:0]) +: DATA_W];
          first_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!stall) begin
          count_d  = count_q + 8'd1;
          rr_ptr_d = win_q + 2'd1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      win_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      first_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      first_q  <= first_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    ack       = '0;
    wr_valid  = 1'b0;
    we_onehot = '0;
    wr_data   = '0;
    if (state_q == StIssue) begin
      wr_valid = 1'b1;
      wr_data  = data_q;
      if (first_q) ack = 4'b0001 << win_q;
      // Entry 0 is hardwired: the write still handshakes but enables nothing.
      if (addr_q != 3'd0) we_onehot = 8'b0000_0001 << addr_q;
    end
  end

  assign wr_count = count_q;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Directed bench for wr_port_arbiter: single write, rotation, stall, addr 0,
// reset abort and count wrap, with hand-computed expectations.
module tb_wr_port_arbiter;

  localparam int unsigned DATA_W = 32;

  logic                clock;
  logic                reset;
  logic [3:0]          req;
  logic [11:0]         req_addr;
  logic [4*DATA_W-1:0] req_data;
  logic                stall;
  logic [3:0]          ack;
  logic                wr_valid;
  logic [7:0]          we_onehot;
  logic [DATA_W-1:0]   wr_data;
  logic [7:0]          wr_count;

  int n_checks = 0;
  int n_pass   = 0;

  wr_port_arbiter #(.DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .stall     (stall),
    .ack       (ack),
    .wr_valid  (wr_valid),
    .we_onehot (we_onehot),
    .wr_data   (wr_data),
    .wr_count  (wr_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [31:0] d);
    req_addr[3*i +: 3]          = a;
    req_data[DATA_W*i +: DATA_W] = d;
  endtask

  task automatic check_idle(input string tag, input logic [7:0] cnt);
    check_val({tag, "_ack"},   32'(ack), 32'h0);
    check_val({tag, "_valid"}, 32'(wr_valid), 32'h0);
    check_val({tag, "_we"},    32'(we_onehot), 32'h0);
    check_val({tag, "_data"},  wr_data, 32'h0);
    check_val({tag, "_count"}, 32'(wr_count), 32'(cnt));
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    stall    = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_idle("reset", 8'd0);
    reset = 1'b0;

    // Single write from requester 2
    req = 4'b0100;
    set_req(2, 3'd5, 32'hDEADBEEF);
    step();
    check_val("single_ack",   32'(ack), 32'h4);
    check_val("single_valid", 32'(wr_valid), 32'h1);
    check_val("single_we",    32'(we_onehot), 32'h20);
    check_val("single_data",  wr_data, 32'hDEADBEEF);
    req = '0;
    step();
    check_idle("single_done", 8'd1);

    // Round robin with all requesters held high
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, 3'(i + 1), 32'h100 + 32'(i));
    for (int g = 0; g < 5; g++) begin
      step();
      check_val("rr_ack",  32'(ack), 32'(4'b0001 << (g % 4)));
      check_val("rr_we",   32'(we_onehot), 32'(8'b0000_0001 << ((g % 4) + 1)));
      check_val("rr_data", wr_data, 32'h100 + 32'(g % 4));
      step();
      check_val("rr_gap_valid", 32'(wr_valid), 32'h0);
    end
    req = '0;
    check_val("rr_count", 32'(wr_count), 32'd5);

    // Stall for three edges; pointer is now 1 so requester 1 is a plain single
    req   = 4'b0010;
    set_req(1, 3'd7, 32'h12345678);
    stall = 1'b1;
    step();
    check_val("stall_ack0", 32'(ack), 32'h2);
    check_val("stall_we0",  32'(we_onehot), 32'h80);
    req = '0;
    set_req(1, 3'd2, 32'h0);
    for (int s = 0; s < 3; s++) begin
      step();
      check_val("stall_ack",   32'(ack), 32'h0);
      check_val("stall_valid", 32'(wr_valid), 32'h1);
      check_val("stall_we",    32'(we_onehot), 32'h80);
      check_val("stall_data",  wr_data, 32'h12345678);
      check_val("stall_count", 32'(wr_count), 32'd5);
    end
    stall = 1'b0;
    step();
    check_idle("stall_done", 8'd6);

    // Address zero still handshakes but enables nothing
    req = 4'b0001;
    set_req(0, 3'd0, 32'hCAFE0000);
    step();
    check_val("a0_ack",   32'(ack), 32'h1);
    check_val("a0_valid", 32'(wr_valid), 32'h1);
    check_val("a0_we",    32'(we_onehot), 32'h0);
    check_val("a0_data",  wr_data, 32'hCAFE0000);
    req = '0;
    step();
    check_val("a0_count", 32'(wr_count), 32'd7);

    // Reset while stalled in ISSUE aborts the write and clears the pointer
    req   = 4'b0100;
    set_req(2, 3'd5, 32'h55AA55AA);
    stall = 1'b1;
    step();
    check_val("abort_pre_valid", 32'(wr_valid), 32'h1);
    req   = '0;
    reset = 1'b1;
    step();
    check_idle("abort", 8'd0);
    reset = 1'b0;
    stall = 1'b0;
    req   = 4'b1010;
    set_req(1, 3'd3, 32'h11111111);
    set_req(3, 3'd6, 32'h33333333);
    step();
    check_val("abort_rr_ack", 32'(ack), 32'h2);
    check_val("abort_rr_we",  32'(we_onehot), 32'h08);
    req = '0;
    step();
    check_val("abort_rr_count", 32'(wr_count), 32'd1);

    // 256 completions wrap the count back to zero
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b0001;
    set_req(0, 3'd3, 32'h0);
    repeat (255) begin
      @(posedge clock);
      @(posedge clock);
    end
    @(negedge clock);
    check_val("wrap_255", 32'(wr_count), 32'hFF);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check_val("wrap_0", 32'(wr_count), 32'h0);
    req = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
